qos_rr_aging_arbiter: RTL and testbench

QOS_RR_AGING_ARBITER -- requirements
Module: qos_rr_aging_arbiter

---
 rtl/qos_rr_aging_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_qos_rr_aging_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qos_rr_aging_arbiter.sv
// ---------------------------------------------------------------------------
// qos_rr_aging_arbiter
//
// Packet-level arbiter for STREAM_COUNT requesting streams. A decision is
// taken in IDLE. The winner keeps a registered one-hot grant until its packet
// ends, either on last&ready or because its request drops. Priority tiers, in
// order, are:
//   1. Starved ("aged") streams whose wait counter has reached AGE_LIMIT.
//   2. Requesting streams whose qos equals the maximum requesting qos.
// Ties inside the winning tier rotate round-robin, starting after the
// previous winner.
//
// Ports
//   clk          rising-edge clock
//   nrst         asynchronous active-low reset
//   en           permits new arbitration decisions (IDLE only)
//   req[N]       per-stream request, held for the whole packet
//   qos[N]       per-stream priority, larger = higher, sampled at decision
//   last[N]      per-stream final-beat marker
//   ready        downstream accepts the current beat
//   grant[N]     registered one-hot grant
//   grant_valid  OR of grant
//   grant_idx    index of the granted stream, held while grant_valid=0
// ---------------------------------------------------------------------------
module qos_rr_aging_arbiter #(
   parameter int STREAM_COUNT = 4,
   parameter int T_QOS__WIDTH = 4,
   parameter int AGE_LIMIT    = 8
) (
   input  logic                            clk,
   input  logic                            nrst,
   input  logic                            en,
   input  logic [STREAM_COUNT-1:0]         req,
   input  logic [T_QOS__WIDTH-1:0]         qos [STREAM_COUNT],
   input  logic [STREAM_COUNT-1:0]         last,
   input  logic                            ready,
   output logic [STREAM_COUNT-1:0]         grant,
   output logic                            grant_valid,
   output logic [$clog2(STREAM_COUNT)-1:0] grant_idx
);

   localparam int IDX_W = $clog2(STREAM_COUNT);
   // With aging disabled, a 1-bit counter is kept so the declaration stays
   // legal. It is never allowed to leave zero.
   localparam int AGE_W = (AGE_LIMIT > 0) ? $clog2(AGE_LIMIT + 1) : 1;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [STREAM_COUNT-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic [AGE_W-1:0]        age_q [STREAM_COUNT];
   logic [AGE_W-1:0]        age_d [STREAM_COUNT];

   logic [T_QOS__WIDTH-1:0] max_qos;
   logic [STREAM_COUNT-1:0] aged;
   logic [STREAM_COUNT-1:0] eligible;
   logic                    win_found;
   logic [IDX_W-1:0]        win_idx;
   logic                    issue;

   assign grant       = grant_q;
   assign grant_valid = |grant_q;
   assign grant_idx   = idx_q;

   // ------------------------------------------------------------------------
   // Winner selection (only consumed in IDLE)
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable written here gets a default first; a path that
      // leaves one unassigned would infer a latch.
      max_qos = '0;
      for (int i = 0; i < STREAM_COUNT; i++) begin
         if (req[i] && (qos[i] > max_qos)) begin
            max_qos = qos[i];
         end
      end
   end

   always_comb begin
      aged     = '0;
      eligible = '0;
      for (int i = 0; i < STREAM_COUNT; i++) begin
         aged[i] = (AGE_LIMIT > 0) && req[i] && (age_q[i] == AGE_W'(AGE_LIMIT));
      end
      // Starved streams pre-empt the qos tier entirely.
      for (int i = 0; i < STREAM_COUNT; i++) begin
         eligible[i] = (|aged) ? aged[i] : (req[i] && (qos[i] == max_qos));
      end
   end

   // Round-robin: the first eligible stream after rr_ptr, ascending with wrap.
   always_comb begin
      int cand;
      cand      = 0;
      win_found = 1'b0;
      win_idx   = '0;
      for (int off = 1; off <= STREAM_COUNT; off++) begin
         cand = int'(rr_ptr_q) + off;
         if (cand >= STREAM_COUNT) begin
            cand = cand - STREAM_COUNT;
         end
         if (!win_found && eligible[cand]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(cand);
         end
      end
   end

   // ------------------------------------------------------------------------
   // FSM next state and grant
   // ------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      idx_d    = idx_q;
      rr_ptr_d = rr_ptr_q;
      issue    = 1'b0;
      case (state_q)
         IDLE: begin
            grant_d = '0;
            if (en && win_found) begin
               issue          = 1'b1;
               state_d        = LOCKED;
               grant_d[win_idx] = 1'b1;
               idx_d          = win_idx;
               rr_ptr_d       = win_idx;
            end
         end
         LOCKED: begin
            // A dropped request aborts the packet whatever ready/last say.
            // The release cycle never arbitrates, so grants are always
            // separated by at least one grant=0 cycle.
            if (!req[idx_q] || (ready && last[idx_q])) begin
               state_d = IDLE;
               grant_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Per-stream wait counters
   // ------------------------------------------------------------------------
   always_comb begin
      for (int i = 0; i < STREAM_COUNT; i++) begin
         if (!req[i] || grant_q[i] || (issue && (win_idx == IDX_W'(i)))) begin
            age_d[i] = '0;
         end else if (age_q[i] < AGE_W'(AGE_LIMIT)) begin
            age_d[i] = age_q[i] + AGE_W'(1);
         end else begin
            age_d[i] = age_q[i];
         end
      end
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         idx_q    <= '0;
         // Pointing at the last stream makes stream 0 win the first tie.
         rr_ptr_q <= IDX_W'(STREAM_COUNT - 1);
         // NOTE: the age array is a handful of flops feeding the priority
         // decision, not a RAM, so every entry must be reset.
         for (int i = 0; i < STREAM_COUNT; i++) begin
            age_q[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments here keep every register sampling
         // the pre-edge values computed by the combinational blocks.
         state_q  <= state_d;
         grant_q  <= grant_d;
         idx_q    <= idx_d;
         rr_ptr_q <= rr_ptr_d;
         for (int i = 0; i < STREAM_COUNT; i++) begin
            age_q[i] <= age_d[i];
         end
      end
   end

endmodule

// File: tb/tb_qos_rr_aging_arbiter.sv
// ---------------------------------------------------------------------------
// Self-checking bench for qos_rr_aging_arbiter (4 streams, 4-bit qos,
// AGE_LIMIT 8). It applies a vector table, hand-written multi-cycle
// sequences and randomized traffic checked against a behavioural model.
// ---------------------------------------------------------------------------
module tb_qos_rr_aging_arbiter;

   localparam int N   = 4;
   localparam int QW  = 4;
   localparam int AGE = 8;

   logic          clk = 1'b0;
   logic          nrst;
   logic          en;
   logic [N-1:0]  req;
   logic [QW-1:0] qos [N];
   logic [N-1:0]  last;
   logic          ready;
   logic [N-1:0]  grant;
   logic          grant_valid;
   logic [1:0]    grant_idx;

   int n_checks = 0;
   int n_errors = 0;

   qos_rr_aging_arbiter #(
      .STREAM_COUNT(N),
      .T_QOS__WIDTH(QW),
      .AGE_LIMIT   (AGE)
   ) dut (
      .clk        (clk),
      .nrst       (nrst),
      .en         (en),
      .req        (req),
      .qos        (qos),
      .last       (last),
      .ready      (ready),
      .grant      (grant),
      .grant_valid(grant_valid),
      .grant_idx  (grant_idx)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ------------------------------------------------------------------------
   // Behavioural model: a packet owner, a last-winner pointer and wait ages
   // ------------------------------------------------------------------------
   bit m_locked;
   int m_g;
   int m_rr;
   int m_idx;
   int m_age [N];

   task automatic model_reset();
      m_locked = 0;
      m_g      = 0;
      m_rr     = N - 1;
      m_idx    = 0;
      for (int i = 0; i < N; i++) m_age[i] = 0;
   endtask

   // Build the candidate set from the tier rules, then take the candidate
   // nearest after the last winner, measured in ring distance.
   function automatic int model_pick();
      int cands[$];
      int maxq;
      int best;
      int best_d;
      maxq = -1;
      for (int i = 0; i < N; i++)
         if (req[i] && m_age[i] == AGE) cands.push_back(i);
      if (cands.size() == 0) begin
         for (int i = 0; i < N; i++)
            if (req[i] && int'(qos[i]) > maxq) maxq = int'(qos[i]);
         for (int i = 0; i < N; i++)
            if (req[i] && int'(qos[i]) == maxq) cands.push_back(i);
      end
      best   = -1;
      best_d = N + 1;
      foreach (cands[k]) begin
         int d;
         d = (cands[k] - m_rr - 1 + 2 * N) % N;
         if (d < best_d) begin
            best_d = d;
            best   = cands[k];
         end
      end
      return best;
   endfunction

   // Advance the model across one rising edge using the current inputs.
   task automatic model_edge();
      int  w;
      bit  issue;
      w     = -1;
      issue = 0;
      if (!m_locked && en && (req != '0)) begin
         w     = model_pick();
         issue = 1;
      end
      for (int i = 0; i < N; i++) begin
         if (!req[i] || (m_locked && m_g == i) || (issue && w == i)) m_age[i] = 0;
         else if (m_age[i] < AGE) m_age[i]++;
      end
      if (m_locked) begin
         if (!req[m_g] || (ready && last[m_g])) m_locked = 0;
      end else if (issue) begin
         m_locked = 1;
         m_g      = w;
         m_rr     = w;
         m_idx    = w;
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic set_qos_all(input int v);
      for (int i = 0; i < N; i++) qos[i] = QW'(v);
   endtask

   task automatic apply_reset();
      nrst  = 1'b0;
      en    = 1'b0;
      req   = '0;
      last  = '0;
      ready = 1'b0;
      set_qos_all(0);
      model_reset();
      @(posedge clk);
      #1;
      nrst = 1'b1;
   endtask

   task automatic check_out(input string name, input logic [3:0] g, input logic [1:0] idx);
      check({name, ".grant"}, 32'(grant), 32'(g));
      check({name, ".valid"}, 32'(grant_valid), 32'(g != 4'b0000));
      check({name, ".idx"}, 32'(grant_idx), 32'(idx));
   endtask

   // ------------------------------------------------------------------------
   // Vector table: each record is applied for one cycle from reset
   // ------------------------------------------------------------------------
   typedef struct packed {
      logic        en;
      logic [3:0]  req;
      logic [15:0] qos;      // stream 3 in [15:12] ... stream 0 in [3:0]
      logic [3:0]  last;
      logic        ready;
      logic [3:0]  exp_grant;
      logic [1:0]  exp_idx;
   } vec_t;

   vec_t vecs [10];

   initial begin
      logic [3:0] exp33 [11];

      vecs[0] = '{en:1'b0, req:4'b1111, qos:16'h3333, last:4'b0000, ready:1'b1, exp_grant:4'b0000, exp_idx:2'd0};
      vecs[1] = '{en:1'b1, req:4'b0110, qos:16'h0550, last:4'b0000, ready:1'b0, exp_grant:4'b0010, exp_idx:2'd1};
      vecs[2] = '{en:1'b1, req:4'b0110, qos:16'h0950, last:4'b0010, ready:1'b0, exp_grant:4'b0010, exp_idx:2'd1};
      vecs[3] = '{en:1'b1, req:4'b0110, qos:16'h0950, last:4'b0100, ready:1'b1, exp_grant:4'b0010, exp_idx:2'd1};
      vecs[4] = '{en:1'b1, req:4'b0110, qos:16'h0550, last:4'b0010, ready:1'b1, exp_grant:4'b0000, exp_idx:2'd1};
      vecs[5] = '{en:1'b1, req:4'b0110, qos:16'h0550, last:4'b0000, ready:1'b0, exp_grant:4'b0100, exp_idx:2'd2};
      vecs[6] = '{en:1'b1, req:4'b0010, qos:16'h0550, last:4'b0000, ready:1'b0, exp_grant:4'b0000, exp_idx:2'd2};
      vecs[7] = '{en:1'b1, req:4'b1001, qos:16'h1001, last:4'b0000, ready:1'b0, exp_grant:4'b1000, exp_idx:2'd3};
      vecs[8] = '{en:1'b1, req:4'b1001, qos:16'h1001, last:4'b1000, ready:1'b1, exp_grant:4'b0000, exp_idx:2'd3};
      vecs[9] = '{en:1'b1, req:4'b1001, qos:16'h1001, last:4'b0000, ready:1'b0, exp_grant:4'b0001, exp_idx:2'd0};

      // Reset state
      apply_reset();
      check_out("reset", 4'b0000, 2'd0);

      // Table
      foreach (vecs[v]) begin
         en    = vecs[v].en;
         req   = vecs[v].req;
         last  = vecs[v].last;
         ready = vecs[v].ready;
         for (int i = 0; i < N; i++) qos[i] = vecs[v].qos[i*4 +: 4];
         tick();
         check_out($sformatf("vec%0d", v), vecs[v].exp_grant, vecs[v].exp_idx);
      end

      // Equal qos, 1-beat packets: 0,1,2,3,0 with one idle cycle between
      apply_reset();
      en = 1'b1; req = 4'b1111; last = 4'b1111; ready = 1'b1; set_qos_all(3);
      for (int k = 0; k < 9; k++) begin
         tick();
         check($sformatf("rr.grant%0d", k), 32'(grant),
               (k % 2 == 0) ? 32'(1 << ((k / 2) % 4)) : 32'd0);
      end

      // qos filter: only streams 1 and 2, alternating
      apply_reset();
      en = 1'b1; req = 4'b1111; last = 4'b1111; ready = 1'b1;
      qos[0] = 4'd2; qos[1] = 4'd7; qos[2] = 4'd7; qos[3] = 4'd1;
      for (int k = 0; k < 8; k++) begin
         tick();
         check($sformatf("qos.grant%0d", k), 32'(grant),
               (k % 2 == 0) ? ((k % 4 == 0) ? 32'h2 : 32'h4) : 32'd0);
      end

      // Aging: low-qos stream 0 wins after waiting 8 cycles
      apply_reset();
      en = 1'b1; req = 4'b0011; last = 4'b0011; ready = 1'b1;
      set_qos_all(0); qos[0] = 4'd1; qos[1] = 4'd9;
      exp33 = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000,
                4'b0010, 4'b0000, 4'b0001, 4'b0000, 4'b0010};
      for (int k = 0; k < 11; k++) begin
         tick();
         check($sformatf("age.grant%0d", k), 32'(grant), 32'(exp33[k]));
      end

      // Multi-beat hold with ready toggling; a qos raise mid-packet is ignored
      apply_reset();
      en = 1'b1; req = 4'b0100; last = '0; ready = 1'b0; set_qos_all(5);
      tick();
      check("hold.first", 32'(grant), 32'h4);
      for (int c = 0; c < 7; c++) begin
         ready = (c % 2 == 0);
         last  = (c >= 5) ? 4'b0100 : 4'b0000;
         if (c == 1) begin
            req    = 4'b1100;
            qos[3] = 4'd15;
         end
         tick();
         check($sformatf("hold.c%0d", c), 32'(grant), (c == 6) ? 32'h0 : 32'h4);
      end
      last = '0; ready = 1'b0;
      tick();
      check_out("hold.next", 4'b1000, 2'd3);

      // Abort on request drop; en=0 blocks new grants
      apply_reset();
      en = 1'b1; req = 4'b0010; set_qos_all(2);
      tick();
      check_out("abort.grant", 4'b0010, 2'd1);
      req = 4'b1101; en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         check_out($sformatf("abort.idle%0d", k), 4'b0000, 2'd1);
      end
      en = 1'b1;
      tick();
      check_out("abort.regrant", 4'b0100, 2'd2);

      // Asynchronous reset mid-packet
      apply_reset();
      en = 1'b1; req = 4'b0100; set_qos_all(4);
      tick();
      check_out("areset.pre", 4'b0100, 2'd2);
      #1 nrst = 1'b0;
      #1;
      check_out("areset.async", 4'b0000, 2'd0);
      model_reset();
      @(posedge clk);
      #1;
      check_out("areset.held", 4'b0000, 2'd0);
      nrst = 1'b1; req = 4'b1111;
      tick();
      check_out("areset.first", 4'b0001, 2'd0);

      // Randomized traffic against the model
      apply_reset();
      for (int i = 0; i < N; i++) req[i] = 1'($urandom_range(0, 1));
      for (int k = 0; k < 3000; k++) begin
         en    = ($urandom_range(0, 3) != 0);
         ready = 1'($urandom_range(0, 1));
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
            last[i] = ($urandom_range(0, 2) == 0);
            qos[i]  = QW'($urandom_range(0, 3));
         end
         tick();
         check("rand.grant", 32'(grant), m_locked ? 32'(1 << m_g) : 32'd0);
         check("rand.valid", 32'(grant_valid), 32'(m_locked));
         check("rand.idx", 32'(grant_idx), 32'(m_idx));
         check("rand.onehot", 32'($countones(grant) <= 1), 32'd1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
